// File: rtl/serial_twos_deser.sv
// -----------------------------------------------------------------------------
// serial_twos_deser
//
// Deserialises an LSB-first serial bit stream into a W-bit parallel word while
// applying a serial two's complement on the fly: each bit is copied up to and
// including the first 1 of the frame, and inverted after that. Feeding the
// output of a serial complementer through this block therefore recovers the
// original value.
//
// Ports:
//   clk     - single clock, all state updates on the rising edge
//   r       - synchronous active-high reset
//   start   - frame start; din in the same cycle is bit 0 of the frame
//   din     - serial input bit, LSB first, one bit per clock
//   dout    - recovered parallel word (registered, held between dvalid pulses)
//   dvalid  - one-cycle pulse when dout has been updated
//   busy    - high while a frame is being shifted in
//   mag_ovf - high with dvalid when dout is the most-negative value
//   abort   - one-cycle pulse when a frame is restarted before completion
// -----------------------------------------------------------------------------
module serial_twos_deser #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         r,
    input  logic         start,
    input  logic         din,
    output logic [W-1:0] dout,
    output logic         dvalid,
    output logic         busy,
    output logic         mag_ovf,
    output logic         abort
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          seen_q,  seen_d;
    logic [W-1:0]  sreg_q,  sreg_d;
    logic [W-1:0]  dout_q,  dout_d;
    logic          dvalid_q, dvalid_d;
    logic          mag_q,   mag_d;
    logic          abort_q, abort_d;

    logic          obit_s;
    logic [W-1:0]  word_s;
    logic          last_s;

    // Complemented bit and the word as it looks once this bit is shifted in.
    // Bits enter at the MSB and move right, so sample k lands at position k
    // after W samples.
    assign obit_s = din ^ seen_q;
    assign word_s = {obit_s, sreg_q[W-1:1]};
    assign last_s = (state_q == SHIFT) && !start && (count_q == LAST_IDX);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q  <= IDLE;
            count_q  <= '0;
            seen_q   <= 1'b0;
            sreg_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            mag_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            seen_q   <= seen_d;
            sreg_q   <= sreg_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            mag_q    <= mag_d;
            abort_q  <= abort_d;
        end
    end

    // Next-state logic: start always (re)enters SHIFT, last bit returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (start) begin
                    state_d = SHIFT;
                end else if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        count_d  = count_q;
        seen_d   = seen_q;
        sreg_d   = sreg_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        mag_d    = 1'b0;
        abort_d  = 1'b0;
        if (start) begin
            // Bit 0 of a new frame: seen_one is clear, so the bit passes through.
            count_d = CW'(1);
            seen_d  = din;
            sreg_d  = {din, {(W-1){1'b0}}};
            abort_d = (state_q == SHIFT);
        end else if (state_q == SHIFT) begin
            count_d = count_q + CW'(1);
            seen_d  = seen_q | din;
            sreg_d  = word_s;
            if (last_s) begin
                dout_d   = word_s;
                dvalid_d = 1'b1;
                mag_d    = (word_s == MOST_NEG);
            end else begin
                dout_d   = dout_q;
                dvalid_d = 1'b0;
            end
        end else begin
            count_d = count_q;
            seen_d  = seen_q;
        end
    end

    assign dout    = dout_q;
    assign dvalid  = dvalid_q;
    assign busy    = (state_q == SHIFT);
    assign mag_ovf = mag_q;
    assign abort   = abort_q;

endmodule

// File: doc/serial_twos_deser.md
SERIAL_TWOS_DESER -- requirements
Module: serial_twos_deser

Interface
REQ-001 SHALL have parameter W, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: frame start; din in the same cycle is bit 0 (LSB) of the frame.
REQ-005 SHALL have port din, input, 1 bit: serial two's-complement bit stream, LSB first, one bit per clk.
REQ-006 SHALL have port dout, output, W bits: recovered (re-negated) parallel word, registered.
REQ-007 SHALL have port dvalid, output, 1 bit: one-cycle pulse marking dout as updated.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is being shifted in.
REQ-009 SHALL have port mag_ovf, output, 1 bit: high with dvalid when the recovered word is 1 followed by W-1 zeros (most-negative value, self-negating).
REQ-010 SHALL have port abort, output, 1 bit: one-cycle pulse when a frame is restarted before completion.

Function
REQ-011 SHALL implement an FSM with states IDLE and SHIFT, a bit counter of width ceil(log2(W+1)), a seen_one flag and a W-bit shift register.
REQ-012 SHALL, per sampled bit, produce obit = din XOR seen_one, then set seen_one = seen_one OR din (serial two's complement: copy up to and including the first 1, invert thereafter).
REQ-013 SHALL place obit of sample k (k = 0..W-1) at bit position k of the assembled word.
REQ-014 SHALL, in IDLE with start=1, sample din as bit 0, set count=1, load seen_one=din and enter SHIFT.
REQ-015 SHALL, in IDLE with start=0, ignore din and hold all state.
REQ-016 SHALL, in SHIFT with start=0, sample din each cycle and increment count.
REQ-017 SHALL, on the edge that samples bit W-1, load dout with the full assembled word, assert dvalid for exactly the following cycle, and return to IDLE.
REQ-018 SHALL therefore have a latency of one cycle from the last bit sampled to dvalid high; a W-bit frame occupies W cycles.
REQ-019 SHALL accept start in the cycle dvalid is high, giving back-to-back frames with no idle gap.
REQ-020 SHALL, in SHIFT with start=1, discard the partial frame, pulse abort for one cycle, and treat the current din as bit 0 of a new frame (count=1, seen_one=din).
REQ-021 SHALL hold dout unchanged between dvalid pulses; an aborted frame SHALL NOT modify dout.
REQ-022 SHALL assert mag_ovf only in the dvalid cycle and only when dout = {1, (W-1) zeros}.
REQ-023 SHALL drive busy high exactly while the FSM is in SHIFT.
REQ-024 SHALL be self-inverse with the serial complementer: for any W-bit value V serialised through the serial complementer, dout SHALL equal V.

Reset
REQ-025 SHALL, when r=1 at a clock edge, force state=IDLE, count=0, seen_one=0, shift register=0, dout=0, dvalid=0, busy=0, mag_ovf=0, abort=0.
REQ-026 SHALL give reset priority over start; r asserted mid-frame SHALL drop the frame without a dvalid or abort pulse.
REQ-027 SHALL ignore start in the cycle following reset deassertion only if r is still high at that edge; the first edge with r=0 SHALL accept start.

Verification (W=8)
REQ-028 SHALL verify: start with din LSB-first 1,1,0,1,1,1,1,1 (0xFB) -> dout=0x05 one cycle after the 8th bit, dvalid=1 for one cycle, mag_ovf=0.
REQ-029 SHALL verify: frame of all zeros -> dout=0x00, dvalid pulse, mag_ovf=0, seen_one never set.
REQ-030 SHALL verify: bits 0,0,0,0,0,0,0,1 (0x80) -> dout=0x80, mag_ovf=1 in the dvalid cycle.
REQ-031 SHALL verify: two frames back-to-back (0xFF then 0x01, start in the dvalid cycle) -> dout=0x01 then 0xFF, two dvalid pulses exactly 8 cycles apart.
REQ-032 SHALL verify: start re-asserted at bit 4 of a frame -> abort pulse, dout unchanged, and the new frame completes 8 cycles after the restart.
REQ-033 SHALL verify: r=1 at bit 3 of a frame -> all outputs 0 the next cycle, no dvalid, and a frame started after r=0 decodes correctly.
